io_controller: RTL

IO_CONTROLLER -- requirements
Module: io_controller

---
 rtl/io_controller.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/io_controller.sv
// Purpose : I/O instruction unit. OUT latches a register value into a display
//           register. IN stalls the core until a debounced button press, then
//           captures the switch bank.
// Latency : OUT - out_data updates and out_valid pulses one edge after out_req
//           in IDLE. IN - DEB_CYCLES+1 edges from the first sampled btn_enter
//           high in WAIT_PRESS to in_valid.
// Backpressure: pc_stall holds the core for the whole IN handshake. Requests
//           that arrive outside IDLE are dropped, so an IN always runs to DONE.
//
// Ports:
//   clock, reset      - system clock; synchronous active-high reset
//   IOE, IOsel, stall - control-unit decode (IOsel=1 IN, IOsel=0 OUT)
//   rs_data           - register-file RS value written by OUT
//   sw_in, btn_enter  - pre-synchronised board switches and confirm button
//   pc_stall          - freezes the PC and blocks writeback while IN waits
//   in_data, in_valid - captured switch word and its one-cycle strobe
//   out_data, out_valid - display register and its one-cycle update strobe
module io_controller #(
  parameter int DATA_W     = 32,
  parameter int SW_W       = 16,  // must not exceed DATA_W
  parameter int DEB_CYCLES = 4    // must be at least 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              IOE,
  input  logic              IOsel,
  input  logic              stall,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [SW_W-1:0]   sw_in,
  input  logic              btn_enter,
  output logic              pc_stall,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  // The counter must be able to hold DEB_CYCLES itself, because the exit test
  // compares against that value.
  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_REL   = 3'd1,
    ST_WAIT_PRESS = 3'd2,
    ST_DEBOUNCE   = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  in_data_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_valid_q;

  logic               in_req;
  logic               out_req;
  logic               in_load;
  logic               out_load;
  logic [DATA_W-1:0]  sw_ext;

  assign in_req  = IOE & IOsel & stall;
  assign out_req = IOE & ~IOsel;

  // Zero-extend by slice assignment so that SW_W == DATA_W needs no
  // zero-width replication.
  always_comb begin
    sw_ext             = '0;
    sw_ext[SW_W-1:0]   = sw_in;
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_load  = 1'b0;
    out_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_req) begin
          state_d = ST_WAIT_REL;
        end else if (out_req) begin
          out_load = 1'b1;
        end
      end

      // A button still held from an earlier IN must be released before it
      // can confirm this one.
      ST_WAIT_REL: begin
        if (!btn_enter) begin
          state_d = ST_WAIT_PRESS;
        end
      end

      // The first sampled high level already counts as one qualifying cycle.
      ST_WAIT_PRESS: begin
        if (btn_enter) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = CNT_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (!btn_enter) begin
          state_d = ST_WAIT_PRESS;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_DONE;
          in_load = 1'b1;
        end else begin
          // Only reached with cnt_q below CNT_MAX, so this cannot wrap.
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_data_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_load;
      if (in_load) begin
        in_data_q <= sw_ext;
      end
      if (out_load) begin
        out_data_q <= rs_data;
      end
    end
  end

  // The stall is combinational so that the IN instruction is frozen in the
  // same cycle it is decoded. It drops in DONE so the PC advances while the
  // captured word is written back.
  always_comb begin
    pc_stall = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE:       pc_stall = in_req;
        ST_WAIT_REL,
        ST_WAIT_PRESS,
        ST_DEBOUNCE:   pc_stall = 1'b1;
        default:       pc_stall = 1'b0;
      endcase
    end
  end

  assign in_data   = in_data_q;
  assign in_valid  = (state_q == ST_DONE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule
